// File: rtl/demixer_iq.sv
// fs/4 quadrature downconverter with integrate-and-dump decimation.
// Ternary LO: phase 0..3 -> I(+,0,-,0), Q(0,-,0,+).
module demixer_iq #(
  parameter int DEC_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [14:0] demix_in,
  input  logic        lo_sync,
  output logic [1:0]  lo_i,
  output logic [1:0]  lo_q,
  output logic [14:0] out_i,
  output logic [14:0] out_q,
  output logic        out_valid
);

  localparam int AW = 16 + DEC_LOG2;
  localparam int SH = DEC_LOG2 - 1;

  logic [DEC_LOG2-1:0] cnt;
  logic [DEC_LOG2-1:0] cnt_next;
  logic signed [AW-1:0] acc_i;
  logic signed [AW-1:0] acc_q;

  logic signed [15:0] x16;
  logic signed [15:0] prod_i;
  logic signed [15:0] prod_q;
  logic signed [AW-1:0] sum_i;
  logic signed [AW-1:0] sum_q;
  logic signed [AW-1:0] shr_i;
  logic signed [AW-1:0] shr_q;
  logic last;

  function automatic logic signed [15:0] apply_lo(
    input logic [1:0] code,
    input logic signed [15:0] x
  );
    logic signed [15:0] r;
    r = '0;
    if (code[1])
      r = -x;
    else if (code[0])
      r = x;
    return r;
  endfunction

  function automatic logic [3:0] lo_code(input logic [1:0] ph);
    logic [3:0] c;
    c = 4'b0100;
    case (ph)
      2'd0: c = 4'b0100;
      2'd1: c = 4'b0010;
      2'd2: c = 4'b1000;
      2'd3: c = 4'b0001;
      default: c = 4'b0100;
    endcase
    return c;
  endfunction

  // Widening to 16 bits first lets -(-16384) land on +16384.
  assign x16    = {demix_in[14], demix_in};
  assign prod_i = apply_lo(lo_i, x16);
  assign prod_q = apply_lo(lo_q, x16);
  assign sum_i  = acc_i + AW'(prod_i);
  assign sum_q  = acc_q + AW'(prod_q);
  assign shr_i  = sum_i >>> SH;
  assign shr_q  = sum_q >>> SH;
  assign last   = (cnt == {DEC_LOG2{1'b1}});

  always_comb begin
    cnt_next = cnt;
    if (lo_sync)
      cnt_next = in_valid ? DEC_LOG2'(1) : '0;
    else if (in_valid)
      cnt_next = cnt + DEC_LOG2'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      lo_i      <= 2'b01;
      lo_q      <= 2'b00;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      cnt       <= cnt_next;
      {lo_i, lo_q} <= lo_code(cnt_next[1:0]);
      if (lo_sync) begin
        acc_i <= in_valid ? AW'(x16) : '0;
        acc_q <= '0;
      end else if (in_valid) begin
        if (last) begin
          acc_i     <= '0;
          acc_q     <= '0;
          out_i     <= shr_i[14:0];
          out_q     <= shr_q[14:0];
          out_valid <= 1'b1;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_demixer_iq.sv
// Directed bench for demixer_iq, DEC_LOG2=3 (N=8).
// Expected values are hand-derived fs/4 block sums.
module tb_demixer_iq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [14:0] demix_in;
  logic        lo_sync;
  logic [1:0]  lo_i;
  logic [1:0]  lo_q;
  logic [14:0] out_i;
  logic [14:0] out_q;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  demixer_iq #(.DEC_LOG2(3)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .demix_in(demix_in),
    .lo_sync(lo_sync),
    .lo_i(lo_i),
    .lo_q(lo_q),
    .out_i(out_i),
    .out_q(out_q),
    .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input int x, input logic s);
    @(negedge clock);
    in_valid = v;
    demix_in = 15'(x);
    lo_sync  = s;
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_lo_i(input int p);
    return (p == 0) ? 1 : (p == 2) ? 2 : 0;
  endfunction

  function automatic int exp_lo_q(input int p);
    return (p == 1) ? 2 : (p == 3) ? 1 : 0;
  endfunction

  // One aligned block of 8 samples from a 4-entry periodic pattern.
  task automatic run_block(input string tag, input int p0, input int p1,
                           input int p2, input int p3,
                           input int ei, input int eq);
    int pat [4];
    pat = '{p0, p1, p2, p3};
    for (int k = 0; k < 8; k++) begin
      step(1'b1, pat[k % 4], 1'b0);
      chk({tag, ".vld"}, int'(out_valid), (k == 7) ? 1 : 0);
      chk({tag, ".lo_i"}, int'(lo_i), exp_lo_i((k + 1) % 4));
      chk({tag, ".lo_q"}, int'(lo_q), exp_lo_q((k + 1) % 4));
    end
    chk({tag, ".out_i"}, int'($signed(out_i)), ei);
    chk({tag, ".out_q"}, int'($signed(out_q)), eq);
  endtask

  initial begin
    int cosp [4];
    cosp = '{1000, 0, -1000, 0};
    reset = 1'b1;
    in_valid = 1'b0;
    demix_in = '0;
    lo_sync = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.lo_i", int'(lo_i), 1);
    chk("rst.lo_q", int'(lo_q), 0);
    chk("rst.out_i", int'(out_i), 0);
    chk("rst.out_q", int'(out_q), 0);
    chk("rst.vld", int'(out_valid), 0);
    reset = 1'b0;

    run_block("cos1", 1000, 0, -1000, 0, 1000, 0);
    run_block("cos2", 1000, 0, -1000, 0, 1000, 0);
    run_block("sin", 0, 1000, 0, -1000, 0, -1000);
    run_block("dc", 1000, 1000, 1000, 1000, 0, 0);
    run_block("maxp", 16383, 0, -16384, 0, 16383, 0);
    run_block("maxn", -16384, 0, 16383, 0, -16384, 0);

    // Partial block, then restart on the 5th sample.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, cosp[k], 1'b0);
      chk("part.vld", int'(out_valid), 0);
    end
    step(1'b1, 1000, 1'b1);
    chk("sync.vld", int'(out_valid), 0);
    chk("sync.lo_i", int'(lo_i), 0);
    chk("sync.lo_q", int'(lo_q), 2);
    for (int k = 1; k < 8; k++) begin
      step(1'b1, cosp[k % 4], 1'b0);
      chk("resync.vld", int'(out_valid), (k == 7) ? 1 : 0);
    end
    chk("resync.out_i", int'($signed(out_i)), 1000);
    chk("resync.out_q", int'($signed(out_q)), 0);

    // Bare lo_sync returns the LO to phase 0.
    step(1'b1, 1000, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("sync0.lo_i", int'(lo_i), 1);
    chk("sync0.lo_q", int'(lo_q), 0);
    chk("sync0.vld", int'(out_valid), 0);

    // Gapped cosine: in_valid 1,0,1,0...
    for (int k = 0; k < 8; k++) begin
      step(1'b1, cosp[k % 4], 1'b0);
      chk("gap.vld", int'(out_valid), (k == 7) ? 1 : 0);
      step(1'b0, 12345, 1'b0);
      chk("gap.idle", int'(out_valid), 0);
    end
    chk("gap.out_i", int'($signed(out_i)), 1000);
    chk("gap.out_q", int'($signed(out_q)), 0);

    // Reset mid-block drops the partial sums.
    for (int k = 0; k < 3; k++)
      step(1'b1, cosp[k], 1'b0);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("mrst.lo_i", int'(lo_i), 1);
    chk("mrst.lo_q", int'(lo_q), 0);
    chk("mrst.out_i", int'(out_i), 0);
    chk("mrst.out_q", int'(out_q), 0);
    chk("mrst.vld", int'(out_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    run_block("post", 0, 1000, 0, -1000, 0, -1000);

    step(1'b0, 0, 1'b0);
    chk("hold.vld", int'(out_valid), 0);
    chk("hold.out_q", int'($signed(out_q)), -1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
